m_fifo36_pkt_arb: RTL and testbench
===================================

# m_fifo36_pkt_arb

Two-input packet arbiter for the 36-bit short-FIFO streaming interface. It shares one FIFO write port (datain/src_rdy_i/dst_rdy_o of a downstream m_fifo_short_w36) between two requesting streams. Grants switch only at packet boundaries, so frames are never interleaved. Round-robin or fixed priority is selected by parameter, and per-input packet counters are provided for status.

## Interface
Parameters:
- PRIO, default 0, arbitration mode: 0 = round-robin, 1 = input 0 has strict priority
- CNT_W, default 16, width of per-input packet counters

Line format on all data buses:
- [31:0] payload
- [32] SOF
- [33] EOF
- [35:34] occupancy
- The block interprets only EOF; all 36 bits pass through unchanged.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear, active-high; same effect as reset
- data0_i  in  36  input 0 line
- src0_rdy_i  in  1  input 0 has valid line
- dst0_rdy_o  out  1  arbiter accepts input 0 line
- data1_i  in  36  input 1 line
- src1_rdy_i  in  1  input 1 has valid line
- dst1_rdy_o  out  1  arbiter accepts input 1 line
- dataout  out  36  line toward FIFO datain
- src_rdy_o  out  1  dataout valid
- dst_rdy_i  in  1  FIFO can accept (FIFO dst_rdy_o)
- active  out  2  one-hot current grant; 00 = idle
- pkt_cnt0  out  CNT_W  packets forwarded from input 0
- pkt_cnt1  out  CNT_W  packets forwarded from input 1

## Operation
- State machine states: IDLE, SEND0, SEND1. State is a register; data and ready paths are combinational from the state, with zero added latency.
- IDLE outputs:
  - src_rdy_o=0, dst0_rdy_o=0, dst1_rdy_o=0
  - dataout=data0_i (don't-care, but deterministic)
  - active=00
- SENDk outputs:
  - dataout=datak_i, src_rdy_o=srck_rdy_i, dstk_rdy_o=dst_rdy_i
  - the other input's dst_rdy_o=0
  - active bit k set
- A transfer from input k occurs in any cycle with state SENDk, srck_rdy_i=1 and dst_rdy_i=1.
- Arbitration function, evaluated on the current src0_rdy_i/src1_rdy_i:
  - Only one request: grant that input.
  - Both requesting, PRIO=1: grant input 0.
  - Both requesting, PRIO=0: grant the input not in the `last` register.
  - Neither requesting: go to IDLE.
- IDLE transitions: apply the arbitration function every cycle; the grant takes effect the next cycle.
- SENDk transitions:
  - Stay in SENDk until a transfer with EOF (bit 33)=1.
  - In the EOF cycle, apply the arbitration function. The next state is that grant, or IDLE if there is no request. This allows back-to-back packets with no bubble.
  - `last` is set to k.
- SOF is not checked. A stream that never sends EOF holds the grant indefinitely; this is by design.
- Counters: pkt_cntk increments by 1 on each EOF transfer from input k, and wraps from all-ones to 0.
- Reset or clear, including mid-packet:
  - state=IDLE, last=1 (so the first tie goes to input 0), both counters=0
  - a partially forwarded packet is abandoned; the downstream FIFO is expected to be cleared alongside.
- clear overrides any transfer in the same cycle: the counter does not increment and the state goes to IDLE.

## Timing
- Reset values: active=00, src_rdy_o=0, dst0_rdy_o=0, dst1_rdy_o=0, pkt_cnt0=0, pkt_cnt1=0.
- Request in IDLE at cycle n: grant at n+1; first transfer possible at n+1 if dst_rdy_i=1.
- During a grant, data/valid/ready are pure pass-through: there is no pipeline register and no extra cycle per line.
- EOF transfer at cycle n with the other input requesting: the other input's first line transfers at n+1.
- Counter value is visible the cycle after the EOF transfer.
- dst_rdy_i low stalls the granted input only. The grant never changes while a packet is stalled.

## Test plan
- Single stream: input 0 sends a 3-line packet (EOF on line 3), dst_rdy_i=1 → active=01 from the cycle after the request, 3 transfers in consecutive cycles, IDLE after EOF, pkt_cnt0=1.
- Tie with PRIO=0: both inputs continuously send 2-line packets → grants alternate 0,1,0,1 with no idle cycle between packets. After 4 packets, pkt_cnt0=2 and pkt_cnt1=2.
- Tie with PRIO=1: same stimulus → input 0 wins every packet and pkt_cnt1 stays 0 while input 0 keeps requesting.
- Backpressure: dst_rdy_i toggles 1,0,1,0 mid-packet from input 1 while input 0 requests → dataout holds the line during stall cycles, active stays 10 until the EOF transfer, and dst0_rdy_o stays 0 throughout.
- Reset mid-packet: reset asserted (low) after line 2 of 4 → outputs go to reset values immediately, asynchronously. After release, the first tie grants input 0.
- Counter wrap and clear: CNT_W=4, 16 packets on input 0 → pkt_cnt0 returns to 0. Assert clear during an EOF transfer → no increment, state IDLE next cycle.

Source files
------------

// File: rtl/m_fifo36_pkt_arb_if.sv
// Bundle of the two request streams and the shared output toward the FIFO write port.
// No logic of its own; the arbiter connects through the slave modport.
// The environment (sources plus downstream FIFO) connects through the master modport.
interface m_fifo36_pkt_arb_if;
    logic [35:0] data0_i;
    logic        src0_rdy_i;
    logic        dst0_rdy_o;
    logic [35:0] data1_i;
    logic        src1_rdy_i;
    logic        dst1_rdy_o;
    logic [35:0] dataout;
    logic        src_rdy_o;
    logic        dst_rdy_i;

    // Arbiter side: takes the two streams in and drives the merged stream out.
    modport slave (
        input  data0_i, src0_rdy_i, data1_i, src1_rdy_i, dst_rdy_i,
        output dst0_rdy_o, dst1_rdy_o, dataout, src_rdy_o
    );

    // Environment side: sources drive lines, the FIFO drives its ready.
    modport master (
        output data0_i, src0_rdy_i, data1_i, src1_rdy_i, dst_rdy_i,
        input  dst0_rdy_o, dst1_rdy_o, dataout, src_rdy_o
    );
endinterface

// File: rtl/m_fifo36_pkt_arb.sv
// Two-input packet arbiter sharing one 36-bit FIFO write port; grants switch only on EOF.
// Zero added latency: data/valid/ready are combinational pass-through from the granted input.
// dst_rdy_i low stalls only the granted input; the other input's ready is held low.
module m_fifo36_pkt_arb #(
    parameter int PRIO  = 0,   // 0 = round-robin, 1 = input 0 wins ties
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    m_fifo36_pkt_arb_if.slave  bus,
    output logic [1:0]         active,
    output logic [CNT_W-1:0]   pkt_cnt0,
    output logic [CNT_W-1:0]   pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t arb_grant;
    logic   last;        // input that most recently finished a packet
    logic   last_nxt;
    logic   arb_last;    // value of last the arbitration should honour this cycle
    logic   xfer0;
    logic   xfer1;
    logic   eof0;
    logic   eof1;

    // Transfer and end-of-packet detection for the granted input.
    always_comb begin
        xfer0 = (state == SEND0) && bus.src0_rdy_i && bus.dst_rdy_i;
        xfer1 = (state == SEND1) && bus.src1_rdy_i && bus.dst_rdy_i;
        eof0  = xfer0 && bus.data0_i[33];
        eof1  = xfer1 && bus.data1_i[33];
    end

    // Arbitration on the current requests; in an EOF cycle the finishing input counts
    // as last already, so a tie hands over to the other input without a bubble.
    always_comb begin
        arb_last = last;
        if (eof0) begin
            arb_last = 1'b0;
        end else if (eof1) begin
            arb_last = 1'b1;
        end
        case ({bus.src1_rdy_i, bus.src0_rdy_i})
            2'b01:   arb_grant = SEND0;
            2'b10:   arb_grant = SEND1;
            2'b11:   arb_grant = ((PRIO != 0) || arb_last) ? SEND0 : SEND1;
            default: arb_grant = IDLE;
        endcase
    end

    // State register: async reset and sync clear both return to IDLE with input 0 favoured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else if (clear) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: re-arbitrate every idle cycle, otherwise only on the EOF transfer.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                state_nxt = arb_grant;
            end
            SEND0: begin
                if (eof0) begin
                    state_nxt = arb_grant;
                    last_nxt  = 1'b0;
                end
            end
            SEND1: begin
                if (eof1) begin
                    state_nxt = arb_grant;
                    last_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs: steer the granted input straight through; idle parks on input 0 data.
    always_comb begin
        bus.dataout    = bus.data0_i;
        bus.src_rdy_o  = 1'b0;
        bus.dst0_rdy_o = 1'b0;
        bus.dst1_rdy_o = 1'b0;
        active         = 2'b00;
        case (state)
            SEND0: begin
                bus.src_rdy_o  = bus.src0_rdy_i;
                bus.dst0_rdy_o = bus.dst_rdy_i;
                active         = 2'b01;
            end
            SEND1: begin
                bus.dataout    = bus.data1_i;
                bus.src_rdy_o  = bus.src1_rdy_i;
                bus.dst1_rdy_o = bus.dst_rdy_i;
                active         = 2'b10;
            end
            default: begin
            end
        endcase
    end

    // Per-input packet counters, bumped on each EOF transfer and wrapping naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (clear) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (eof0) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
            if (eof1) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_m_fifo36_pkt_arb.sv
// Bench for m_fifo36_pkt_arb: round-robin and fixed-priority instances side by side,
// each fed by its own packet sources and checked every cycle against a packet-level model.
// Directed phases cover single stream, ties, stalls, async reset, counter wrap and clear.
module tb_m_fifo36_pkt_arb;
    localparam int CW   = 4;
    localparam int BIG  = 1000000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    m_fifo36_pkt_arb_if ifa ();
    m_fifo36_pkt_arb_if ifb ();

    logic [1:0]    act_a, act_b;
    logic [CW-1:0] c0a, c1a, c0b, c1b;

    m_fifo36_pkt_arb #(.PRIO(0), .CNT_W(CW)) dut_a (
        .clock(clock), .reset(reset), .clear(clear), .bus(ifa.slave),
        .active(act_a), .pkt_cnt0(c0a), .pkt_cnt1(c1a)
    );
    m_fifo36_pkt_arb #(.PRIO(1), .CNT_W(CW)) dut_b (
        .clock(clock), .reset(reset), .clear(clear), .bus(ifb.slave),
        .active(act_b), .pkt_cnt0(c0b), .pkt_cnt1(c1b)
    );

    int checks   = 0;
    int failures = 0;

    // Sources: [dut][input]
    int         s_seq [2][2];
    int         s_pos [2][2];
    int         s_len [2][2];
    int         s_left[2][2];
    logic [1:0] s_occ [2][2];
    logic       s_rdy [2][2];
    logic       g_dst [2];

    // Packet-level reference: owner 0 = nobody, 1 = input 0, 2 = input 1
    int m_own [2];
    int m_last[2];
    int m_cnt [2][2];

    // Stimulus knobs
    int p_req[2];
    int p_dst   = 100;
    int p_clr   = 0;
    int fix_len = 0;
    bit eof_cleared = 0;

    function automatic logic [35:0] line_of(int d, int k);
        logic [31:0] pay;
        pay = {4'(d), 4'(k), 16'(s_seq[d][k]), 8'(s_pos[d][k])};
        return {s_occ[d][k], (s_pos[d][k] == s_len[d][k] - 1), (s_pos[d][k] == 0), pay};
    endfunction

    function automatic int pick(int d, logic r0, logic r1, int lst);
        if (r0 && r1) begin
            if (d == 1) return 1;          // fixed priority instance
            return (lst == 1) ? 1 : 2;     // round robin: not the last one served
        end
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    task automatic new_pkt(int d, int k);
        s_seq[d][k] = s_seq[d][k] + 1;
        s_pos[d][k] = 0;
        s_len[d][k] = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
        s_occ[d][k] = 2'($urandom);
    endtask

    task automatic chk(string tag, int d, logic [35:0] obs, logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset(int d);
        m_own[d]    = 0;
        m_last[d]   = 1;
        m_cnt[d][0] = 0;
        m_cnt[d][1] = 0;
        new_pkt(d, 0);
        new_pkt(d, 1);
    endtask

    task automatic apply_bus();
        ifa.data0_i = line_of(0, 0); ifa.src0_rdy_i = s_rdy[0][0];
        ifa.data1_i = line_of(0, 1); ifa.src1_rdy_i = s_rdy[0][1];
        ifa.dst_rdy_i = g_dst[0];
        ifb.data0_i = line_of(1, 0); ifb.src0_rdy_i = s_rdy[1][0];
        ifb.data1_i = line_of(1, 1); ifb.src1_rdy_i = s_rdy[1][1];
        ifb.dst_rdy_i = g_dst[1];
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                s_rdy[d][k] = (s_left[d][k] > 0) && (int'($urandom_range(0, 99)) < p_req[k]);
            end
            g_dst[d] = (int'($urandom_range(0, 99)) < p_dst);
        end
        apply_bus();
    endtask

    task automatic check_dut(int d, logic [1:0] act, logic sr, logic r0, logic r1,
                             logic [35:0] dout, logic [CW-1:0] c0, logic [CW-1:0] c1);
        logic [1:0]  e_act;
        logic        e_sr;
        logic [35:0] e_dout;
        e_act  = (m_own[d] == 1) ? 2'b01 : (m_own[d] == 2) ? 2'b10 : 2'b00;
        e_sr   = (m_own[d] == 1) ? s_rdy[d][0] : (m_own[d] == 2) ? s_rdy[d][1] : 1'b0;
        e_dout = (m_own[d] == 2) ? line_of(d, 1) : line_of(d, 0);
        chk("active",    d, 36'(act), 36'(e_act));
        chk("src_rdy_o", d, 36'(sr),  36'(e_sr));
        chk("dst0_rdy",  d, 36'(r0),  36'((m_own[d] == 1) && g_dst[d]));
        chk("dst1_rdy",  d, 36'(r1),  36'((m_own[d] == 2) && g_dst[d]));
        chk("dataout",   d, dout,     e_dout);
        chk("pkt_cnt0",  d, 36'(c0),  36'(m_cnt[d][0] % (1 << CW)));
        chk("pkt_cnt1",  d, 36'(c1),  36'(m_cnt[d][1] % (1 << CW)));
    endtask

    task automatic check_all();
        check_dut(0, act_a, ifa.src_rdy_o, ifa.dst0_rdy_o, ifa.dst1_rdy_o, ifa.dataout, c0a, c1a);
        check_dut(1, act_b, ifb.src_rdy_o, ifb.dst0_rdy_o, ifb.dst1_rdy_o, ifb.dataout, c0b, c1b);
    endtask

    // Advance the reference by one clock, using the inputs presented this cycle.
    task automatic step_model();
        int k;
        for (int d = 0; d < 2; d++) begin
            if (clear) begin
                model_reset(d);
            end else if (m_own[d] == 0) begin
                m_own[d] = pick(d, s_rdy[d][0], s_rdy[d][1], m_last[d]);
            end else begin
                k = m_own[d] - 1;
                if (s_rdy[d][k] && g_dst[d]) begin
                    if (s_pos[d][k] == s_len[d][k] - 1) begin
                        m_cnt[d][k] = (m_cnt[d][k] + 1) % (1 << CW);
                        m_last[d]   = k;
                        m_own[d]    = pick(d, s_rdy[d][0], s_rdy[d][1], k);
                        s_left[d][k] = s_left[d][k] - 1;
                        new_pkt(d, k);
                    end else begin
                        s_pos[d][k] = s_pos[d][k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle(bit clr_on_eof);
        int k;
        drive();
        clear = (int'($urandom_range(0, 99)) < p_clr);
        if (clr_on_eof && !eof_cleared && m_own[0] != 0) begin
            k = m_own[0] - 1;
            if (s_rdy[0][k] && g_dst[0] && s_pos[0][k] == s_len[0][k] - 1) begin
                clear       = 1'b1;
                eof_cleared = 1'b1;
            end
        end
        @(negedge clock);
        check_all();
        @(posedge clock);
        step_model();
        #1;
        clear = 1'b0;
    endtask

    task automatic set_left(int l0, int l1);
        for (int d = 0; d < 2; d++) begin
            s_left[d][0] = l0;
            s_left[d][1] = l1;
        end
    endtask

    // Re-shape packets that have not started yet so a phase's length setting applies.
    task automatic refresh_idle_sources();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                if (s_pos[d][k] == 0) new_pkt(d, k);
            end
        end
    endtask

    initial begin
        bit hit;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) s_seq[d][k] = 0;
            model_reset(d);
        end
        p_req[0] = 0;
        p_req[1] = 0;
        set_left(0, 0);

        // Reset state, sampled with reset held and no clock edge yet
        drive();
        #3;
        check_all();
        #4;
        reset = 1'b1;

        // Single stream: one 3-line packet on input 0, sink always ready
        fix_len = 3;
        refresh_idle_sources();
        set_left(1, 0);
        p_req[0] = 100;
        p_req[1] = 0;
        p_dst    = 100;
        repeat (8) cycle(0);

        // Ties: both inputs with 2-line packets back to back
        fix_len = 2;
        refresh_idle_sources();
        set_left(2, 2);
        p_req[0] = 100;
        p_req[1] = 100;
        repeat (14) cycle(0);

        // Backpressure with random requests and packet lengths
        fix_len = 0;
        set_left(BIG, BIG);
        p_req[0] = 70;
        p_req[1] = 70;
        p_dst    = 50;
        repeat (300) cycle(0);

        // Async reset in the middle of a 4-line packet, after its second line
        fix_len  = 4;
        p_req[0] = 100;
        p_req[1] = 100;
        p_dst    = 100;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle(0);
            if (m_own[0] != 0 && s_len[0][m_own[0] - 1] == 4 && s_pos[0][m_own[0] - 1] == 2) hit = 1;
        end
        chk("reset_window_reached", 0, 36'(hit), 36'(1'b1));
        drive();
        #2;
        reset = 1'b0;
        model_reset(0);
        model_reset(1);
        apply_bus();
        #1;
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b1;

        // First tie after reset goes to input 0 on both instances
        s_rdy[0][0] = 1'b1;
        cycle(0);
        chk("tie_after_reset", 0, 36'(act_a), 36'(2'b01));
        chk("tie_after_reset", 1, 36'(act_b), 36'(2'b01));

        // Counter wrap: clear, then 16 single-line packets on input 0 only
        fix_len  = 1;
        p_req[0] = 100;
        p_req[1] = 0;
        p_clr    = 100;
        cycle(0);
        p_clr    = 0;
        set_left(16, 0);
        repeat (20) cycle(0);
        chk("wrap_cnt0", 0, 36'(c0a), 36'(0));
        chk("wrap_cnt0", 1, 36'(c0b), 36'(0));

        // Clear landing on an EOF transfer of the round-robin instance
        fix_len  = 0;
        set_left(BIG, BIG);
        p_req[0] = 80;
        p_req[1] = 80;
        p_dst    = 70;
        for (int i = 0; i < 200 && !eof_cleared; i++) cycle(1);
        chk("clear_on_eof_seen", 0, 36'(eof_cleared), 36'(1'b1));
        chk("idle_after_clear", 0, 36'(act_a), 36'(2'b00));
        chk("cnt_after_clear", 0, 36'({c1a, c0a}), 36'(0));

        // Free-running random traffic with occasional clears
        p_clr = 3;
        repeat (300) cycle(0);
        p_clr = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
